// File: rtl/floating_point_unit_pkg.sv
// Shared FPU types: converter micro-ops, rounding side-band and the
// converter arbiter result record.
package floating_point_unit_pkg;

    localparam int unsigned FCVT_DATA_W    = 32;
    localparam int unsigned FCVT_TAG_MAX_W = 16;

    typedef enum logic [0:0] {
        INT2FLOAT = 1'b0,
        FLOAT2INT = 1'b1
    } fcvt_uop_t;

    typedef struct packed {
        logic guard;
        logic round;
        logic sticky;
    } round_bits_t;

    typedef logic [0:0] fcvt_req_id_t;

    // Tag is held zero-extended so one record type serves any TAG_WIDTH up to the max
    typedef struct packed {
        logic [FCVT_DATA_W-1:0]    result;
        logic [FCVT_TAG_MAX_W-1:0] tag;
        fcvt_req_id_t              req_id;
        logic                      round_enable;
        logic                      inexact;
        logic                      overflow;
        logic                      underflow;
        round_bits_t               round_bits;
    } fcvt_result_t;

    localparam int unsigned FCVT_RESULT_W = $bits(fcvt_result_t);

endpackage

// File: rtl/fcvt_arbiter_sync_fifo.sv
// Synchronous FIFO with occupancy count; pointers wrap modulo a
// power-of-two depth, read data is the head entry.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Storage needs no reset; validity is tracked by the count
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/fcvt_arbiter.sv
// Round-robin arbiter sharing one int<->float converter between two
// requesters, with credit-controlled result buffering.
module fcvt_arbiter
    import floating_point_unit_pkg::*;
#(
    parameter int unsigned TAG_WIDTH  = 6,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [1:0]                         req_valid_i,
    output logic [1:0]                         req_ready_o,
    input  logic [1:0][FCVT_DATA_W-1:0]        req_operand_i,
    input  fcvt_uop_t [1:0]                    req_operation_i,
    input  logic [1:0]                         req_signed_i,
    input  logic [1:0][TAG_WIDTH-1:0]          req_tag_i,
    output logic [FCVT_DATA_W-1:0]             cvt_operand_o,
    output fcvt_uop_t                          cvt_operation_o,
    output logic                               cvt_signed_o,
    output logic                               cvt_valid_o,
    output logic                               cvt_clk_en_o,
    input  logic [FCVT_DATA_W-1:0]             cvt_result_i,
    input  logic                               cvt_valid_i,
    input  logic                               cvt_round_enable_i,
    input  logic                               cvt_inexact_i,
    input  logic                               cvt_overflow_i,
    input  logic                               cvt_underflow_i,
    input  round_bits_t                        cvt_round_bits_i,
    output logic                               res_valid_o,
    input  logic                               res_ready_i,
    output fcvt_result_t                       res_data_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    fcvt_req_id_t           r_prio;
    logic                   r_inflight;
    logic [TAG_WIDTH-1:0]   r_tag;
    fcvt_req_id_t           r_id;
    logic                   r_post_rst;
    logic                   r_err;

    logic [1:0]             w_grant;
    logic                   w_issue;
    fcvt_req_id_t           w_win;
    logic                   w_credit_ok;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [CNT_W-1:0]       w_count;
    fcvt_result_t           w_push_data;
    fcvt_result_t           w_head;

    // A slot is reserved for the in-flight result so nothing is ever dropped
    assign w_credit_ok = (32'(w_count) + 32'(r_inflight)) < 32'(FIFO_DEPTH);

    always_comb begin
        w_grant = 2'b00;
        if (!rst_i && w_credit_ok) begin
            case (req_valid_i)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_prio[0] ? 2'b10 : 2'b01;
                default: w_grant = 2'b00;
            endcase
        end
    end

    assign w_issue         = |w_grant;
    assign w_win           = w_grant[1];
    assign req_ready_o     = w_grant;
    assign cvt_valid_o     = w_issue;
    assign cvt_clk_en_o    = w_issue;
    assign cvt_operand_o   = req_operand_i[w_win];
    assign cvt_operation_o = req_operation_i[w_win];
    assign cvt_signed_o    = req_signed_i[w_win];

    // Priority only moves on contention; a lone requester leaves it untouched
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prio     <= '0;
            r_inflight <= 1'b0;
            r_tag      <= '0;
            r_id       <= '0;
            r_post_rst <= 1'b1;
            r_err      <= 1'b0;
        end else begin
            r_post_rst <= 1'b0;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_tag <= req_tag_i[w_win];
                r_id  <= w_win;
            end
            if (w_issue && (req_valid_i == 2'b11)) r_prio <= ~w_win;
            if (cvt_valid_i && !r_inflight && !r_post_rst) r_err <= 1'b1;
        end
    end

    assign w_push = cvt_valid_i && r_inflight && !rst_i;
    assign w_pop  = res_valid_o && res_ready_i;

    always_comb begin
        w_push_data              = '0;
        w_push_data.result       = cvt_result_i;
        w_push_data.tag          = FCVT_TAG_MAX_W'(r_tag);
        w_push_data.req_id       = r_id;
        w_push_data.round_enable = cvt_round_enable_i;
        w_push_data.inexact      = cvt_inexact_i;
        w_push_data.overflow     = cvt_overflow_i;
        w_push_data.underflow    = cvt_underflow_i;
        w_push_data.round_bits   = cvt_round_bits_i;
    end

    sync_fifo #(
        .WIDTH (FCVT_RESULT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign res_valid_o = !w_empty && !rst_i;
    assign res_data_o  = w_head;

    a_no_orphan_result: assert property (@(posedge clk_i) disable iff (rst_i) !r_err);
    a_no_push_on_full:  assert property (@(posedge clk_i) disable iff (rst_i) !(w_push && w_full));

endmodule

// File: doc/fcvt_arbiter.md
FCVT_ARBITER -- requirements
Module: fcvt_arbiter

Interface
REQ-001 Parameter TAG_WIDTH, default 6, width of the requester instruction tag.
REQ-002 Parameter FIFO_DEPTH, default 2, number of result buffer entries (power of two, >=2).
REQ-003 clk_i  in  1  single clock; all state updates on posedge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 req_valid_i[1:0]  in  2  per-requester request valid (0 = FPU issue, 1 = auxiliary port).
REQ-006 req_ready_o[1:0]  out  2  per-requester request accepted this cycle when valid & ready.
REQ-007 req_operand_i[1:0]  in  2x32  operand to convert.
REQ-008 req_operation_i[1:0]  in  2x fcvt_uop_t  INT2FLOAT / FLOAT2INT.
REQ-009 req_signed_i[1:0]  in  2  integer signedness.
REQ-010 req_tag_i[1:0]  in  2xTAG_WIDTH  instruction tag.
REQ-011 cvt_operand_o / cvt_operation_o / cvt_signed_o  out  32 / fcvt_uop_t / 1  converter inputs.
REQ-012 cvt_valid_o, cvt_clk_en_o  out  1, 1  converter data valid and stage enable.
REQ-013 cvt_result_i, cvt_valid_i, cvt_round_enable_i, cvt_inexact_i, cvt_overflow_i, cvt_underflow_i, cvt_round_bits_i  in  32/1/1/1/1/1/round_bits_t  converter outputs.
REQ-014 res_valid_o, res_ready_i  out/in  1/1  result handshake.
REQ-015 res_data_o  out  fcvt_result_t  {result, tag, requester id, round_enable, inexact, overflow, underflow, round_bits}.

Function
REQ-016 An issue SHALL occur in a cycle where at least one request is valid and credits allow (REQ-022); at most one issue per cycle.
REQ-017 Arbitration SHALL be round-robin: on contention the requester not granted last SHALL win; with a single valid requester it SHALL win without changing priority.
REQ-018 req_ready_o SHALL be one-hot or zero, asserted only for the granted requester, combinationally from valids, priority pointer and credits.
REQ-019 On issue, cvt_* inputs SHALL carry the winner's fields, cvt_valid_o = 1, cvt_clk_en_o = 1; otherwise cvt_valid_o = 0 and cvt_clk_en_o = 0.
REQ-020 Tag and requester id SHALL be registered on issue and paired with the converter output returned one cycle later (cvt_valid_i).
REQ-021 On cvt_valid_i the paired record SHALL be written into the FIFO; res_valid_o SHALL rise the following cycle (issue-to-res_valid_o latency = 2 cycles with empty FIFO).
REQ-022 Credit rule: issue permitted only if FIFO occupancy + in-flight count (0/1) < FIFO_DEPTH; results SHALL never be dropped.
REQ-023 Pop on res_valid_o & res_ready_i; a simultaneous push and pop SHALL leave occupancy unchanged; push on full SHALL not occur (guaranteed by REQ-022).
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; order SHALL be issue order.
REQ-025 res_data_o SHALL be stable while res_valid_o & !res_ready_i.
REQ-026 cvt_valid_i without a matching in-flight issue SHALL set a sticky internal error flag (assertion only, no output).

Reset
REQ-027 While rst_i is high: req_ready_o = 0, cvt_valid_o = 0, cvt_clk_en_o = 0, res_valid_o = 0, occupancy, pointers, in-flight = 0, priority pointer = requester 0.
REQ-028 A reset asserted with an operation in flight SHALL discard it; cvt_valid_i in the first cycle after reset SHALL be ignored.

Structure
REQ-029 fcvt_result_t and the requester id type SHALL live in floating_point_unit_pkg; fcvt_uop_t and round_bits_t are reused from there.
REQ-030 The result buffer SHALL be a sub-module sync_fifo (parameterised width/depth, full/empty/occupancy outputs).

Verification
REQ-031 Both requesters valid for 4 cycles, res_ready_i = 1 -> grants alternate 0,1,0,1; results return in the same order with correct tags.
REQ-032 Requester 0 FLOAT2INT of 0x40490FDB (3.14159), signed -> res_data_o.result = 3, inexact = 1, requester id 0, res_valid_o 2 cycles after issue.
REQ-033 Requester 1 INT2FLOAT of 0xFFFFFFFF, signed -> result 0xBF800000, tag preserved, inexact = 0.
REQ-034 res_ready_i = 0 with continuous requests -> exactly FIFO_DEPTH issues, then req_ready_o = 0; releasing res_ready_i resumes with no loss or duplication.
REQ-035 rst_i asserted the cycle after an issue -> no res_valid_o, occupancy 0, next grant to requester 0.
